// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, assembled word and status strobes out.
// master = the receiver, slave = whoever drives the line and consumes the words.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic             i_rx;
    logic [WIDTH-1:0] o_data;
    logic             o_dv;
    logic             o_frame_err;
    logic             o_busy;

    modport master (input i_rx, output o_data, o_dv, o_frame_err, o_busy);
    modport slave  (output i_rx, input o_data, o_dv, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, WIDTH data, 1 stop, no parity, DIVISOR clks per bit.
// Define UART_RX_GLITCH_FILTER_EN to decide each bit by a 3-sample majority (+1 cycle latency).
module uart_rx #(
    parameter int WIDTH         = 8,
    parameter int DIVISOR       = 100,
    parameter bit LITTLE_ENDIAN = 1
) (
    input  logic      clk,
    input  logic      i_reset,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(DIVISOR);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam logic [CW-1:0] DEC = CW'(DIVISOR / 2);
`else
    localparam logic [CW-1:0] DEC = CW'(DIVISOR / 2 - 1);
`endif
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic             rx_m, rx_s, rx_prev;
    logic             bit_val;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] sr_q, sr_next, data_q;
    logic [WIDTH:0]   sr_ext;
    logic             dv_q, ferr_q;
    logic             at_dec, at_end;
    logic             shift_en, bit_clr, bit_inc, load, ferr_set;

`ifdef UART_RX_GLITCH_FILTER_EN
    // hist[1] = rx_s at cnt M-1, hist[0] = rx_s at cnt M when cnt is at M+1
    logic [1:0] hist;
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign at_dec = (cnt_q == DEC);
    assign at_end = (cnt_q == CNT_MAX);

    generate
        if (LITTLE_ENDIAN) begin : g_le
            assign sr_ext  = {bit_val, sr_q};
            assign sr_next = sr_ext[WIDTH:1];
        end else begin : g_be
            assign sr_ext  = {sr_q, bit_val};
            assign sr_next = sr_ext[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        load     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                // edge-triggered so a line stuck low cannot retrigger
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                if (at_dec && bit_val) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                if (at_dec) shift_en = 1'b1;
                if (at_end) begin
                    bit_inc = 1'b1;
                    if (bit_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                // leave at mid-stop so a back-to-back start edge is not missed
                if (at_dec) begin
                    state_d = IDLE;
                    if (bit_val) load     = 1'b1;
                    else         ferr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
`ifdef UART_RX_GLITCH_FILTER_EN
            hist    <= 2'b11;
`endif
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_m    <= bus.i_rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
`ifdef UART_RX_GLITCH_FILTER_EN
            hist    <= {hist[0], rx_s};
`endif
            if (state_q == IDLE || state_d == IDLE || at_end) cnt_q <= '0;
            else                                              cnt_q <= cnt_q + CW'(1);
            if (bit_clr)      bit_q <= '0;
            else if (bit_inc) bit_q <= bit_q + BW'(1);
            if (shift_en) sr_q <= sr_next;
            if (load)     data_q <= sr_q;
            dv_q   <= load;
            ferr_q <= ferr_set;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_dv        = dv_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one LSB-first and one MSB-first receiver share a behavioural serial line.
module tb_uart_rx;
    localparam int D = 16;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   busy_mid;

    always #5 clk = ~clk;

    uart_rx_if #(.WIDTH(8)) bus_le ();
    uart_rx_if #(.WIDTH(8)) bus_be ();
    assign bus_le.i_rx = rx;
    assign bus_be.i_rx = rx;

    uart_rx #(.WIDTH(8), .DIVISOR(D), .LITTLE_ENDIAN(1)) dut_le (.clk(clk), .i_reset(rst), .bus(bus_le.master));
    uart_rx #(.WIDTH(8), .DIVISOR(D), .LITTLE_ENDIAN(0)) dut_be (.clk(clk), .i_reset(rst), .bus(bus_be.master));

    typedef struct {bit err; int data;} ev_t;
    ev_t ev_le[$];
    ev_t ev_be[$];

    typedef struct {
        logic [7:0] d;
        bit         msb;
        bit         stop;
        int         ndv;
        int         nerr;
        logic [7:0] le;
        logic [7:0] be;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // strobe monitors: log every pulse, check exclusivity and single-cycle width
    bit le_prev = 0, be_prev = 0;
    always @(negedge clk) begin
        if (!rst && (bus_le.o_dv || bus_le.o_frame_err)) begin
            chk("le_excl", int'(bus_le.o_dv & bus_le.o_frame_err), 0);
            chk("le_width", int'(le_prev), 0);
            ev_le.push_back('{bus_le.o_frame_err, int'(bus_le.o_data)});
        end
        le_prev = !rst && (bus_le.o_dv || bus_le.o_frame_err);
    end
    always @(negedge clk) begin
        if (!rst && (bus_be.o_dv || bus_be.o_frame_err)) begin
            chk("be_excl", int'(bus_be.o_dv & bus_be.o_frame_err), 0);
            chk("be_width", int'(be_prev), 0);
            ev_be.push_back('{bus_be.o_frame_err, int'(bus_be.o_data)});
        end
        be_prev = !rst && (bus_be.o_dv || bus_be.o_frame_err);
    end

    function automatic int n_kind(input bit le, input int from, input bit err);
        int n = 0;
        if (le) begin
            for (int i = from; i < ev_le.size(); i++) if (ev_le[i].err == err) n++;
        end else begin
            for (int i = from; i < ev_be.size(); i++) if (ev_be[i].err == err) n++;
        end
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // leaves the line at the stop-bit level; callers decide what follows
    task automatic send_frame(input logic [7:0] d, input bit msb, input bit stop, input bit glitch);
        logic [9:0] fr;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = msb ? d[7-i] : d[i];
        fr[9] = stop;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < D; c++) begin
                rx = (glitch && k >= 1 && k <= 8 && c == D/2 - 1) ? ~fr[k] : fr[k];
                if (k == 5 && c == D/2) busy_mid = bus_le.o_busy;
                tick(1);
            end
        end
    endtask

    vec_t       vt[6];
    logic [7:0] b2b[3];
    ev_t        exp_le[$];
    ev_t        exp_be[$];

    initial begin
        int n0, nb0, lowat, base_le, base_be;
        int last_le, last_be;

        vt[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5, 8'hA5};
        vt[1] = '{8'h3C, 1'b1, 1'b1, 1, 0, 8'h3C, 8'h3C};
        vt[2] = '{8'h01, 1'b0, 1'b1, 1, 0, 8'h01, 8'h80};
        vt[3] = '{8'h80, 1'b1, 1'b1, 1, 0, 8'h01, 8'h80};
        vt[4] = '{8'h55, 1'b0, 1'b0, 0, 1, 8'h01, 8'h80};
        vt[5] = '{8'h12, 1'b1, 1'b1, 1, 0, 8'h48, 8'h12};
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h81;

        tick(3);
        chk("rst_data", int'(bus_le.o_data), 0);
        chk("rst_dv", int'(bus_le.o_dv), 0);
        chk("rst_ferr", int'(bus_le.o_frame_err), 0);
        chk("rst_busy", int'(bus_le.o_busy), 0);
        chk("rst_be_data", int'(bus_be.o_data), 0);
        rst = 1'b0;
        idle(2*D);

        for (int r = 0; r < 6; r++) begin
            n0 = ev_le.size(); nb0 = ev_be.size();
            busy_mid = 1'b0;
            send_frame(vt[r].d, vt[r].msb, vt[r].stop, 1'b0);
            idle(2*D);
            chk($sformatf("vec%0d_le_dv", r), n_kind(1, n0, 0), vt[r].ndv);
            chk($sformatf("vec%0d_le_ferr", r), n_kind(1, n0, 1), vt[r].nerr);
            chk($sformatf("vec%0d_be_dv", r), n_kind(0, nb0, 0), vt[r].ndv);
            chk($sformatf("vec%0d_le_data", r), int'(bus_le.o_data), int'(vt[r].le));
            chk($sformatf("vec%0d_be_data", r), int'(bus_be.o_data), int'(vt[r].be));
            chk($sformatf("vec%0d_busy", r), int'(busy_mid), 1);
        end

        // back-to-back frames, no idle between stop and next start
        n0 = ev_le.size();
        for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b0, 1'b1, 1'b0);
        idle(2*D);
        chk("b2b_count", ev_le.size() - n0, 3);
        for (int i = 0; i < 3; i++) begin
            if (n0 + i < ev_le.size()) begin
                chk($sformatf("b2b%0d_err", i), int'(ev_le[n0+i].err), 0);
                chk($sformatf("b2b%0d_data", i), ev_le[n0+i].data, int'(b2b[i]));
            end
        end

        // false start: short low pulse must not produce output
        n0 = ev_le.size();
        lowat = 0;
        rx = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if (c == D/4) rx = 1'b1;
            if (c > 3 && !bus_le.o_busy) begin
                lowat = c;
                break;
            end
        end
        chk("false_busy_low", int'(lowat >= 3 && lowat <= D/2 + 3 + FILT), 1);
        idle(2*D);
        chk("false_events", ev_le.size() - n0, 0);

        // bad stop then line held low: one error, data held, no retrigger
        n0 = ev_le.size(); nb0 = ev_be.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        tick(3*10*D);
        chk("hold_ferr", n_kind(1, n0, 1), 1);
        chk("hold_dv", n_kind(1, n0, 0), 0);
        chk("hold_be_ferr", n_kind(0, nb0, 1), 1);
        chk("hold_busy", int'(bus_le.o_busy), 0);
        chk("hold_le_data", int'(bus_le.o_data), 8'h81);
        idle(2*D);
        chk("hold_release", ev_le.size() - n0, 1);

        // reset in the middle of DATA, then a clean frame
        n0 = ev_le.size();
        rx = 1'b0; tick(D);
        rx = 1'b1; tick(3*D);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        chk("rst_mid_busy", int'(bus_le.o_busy), 0);
        idle(12*D);
        chk("rst_mid_events", ev_le.size() - n0, 0);
        send_frame(8'h42, 1'b0, 1'b1, bit'(FILT));
        idle(2*D);
        chk("post_rst_dv", n_kind(1, n0, 0), 1);
        chk("post_rst_le_data", int'(bus_le.o_data), 8'h42);
        chk("post_rst_be_data", int'(bus_be.o_data), 8'h42);

        // randomized frames against a frame-level model
        rst = 1'b1; tick(2); rst = 1'b0; idle(2*D);
        base_le = ev_le.size(); base_be = ev_be.size();
        last_le = 0; last_be = 0;
        for (int f = 0; f < 24; f++) begin
            logic [7:0] d;
            bit msb, stop, b;
            int gap, lv, bv;
            d = 8'($urandom);
            msb = bit'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            lv = 0; bv = 0;
            for (int i = 0; i < 8; i++) begin
                b = msb ? d[7-i] : d[i];
                lv += int'(b) << i;
                bv += int'(b) << (7 - i);
            end
            if (stop) begin
                last_le = lv;
                last_be = bv;
            end
            exp_le.push_back('{!stop, last_le});
            exp_be.push_back('{!stop, last_be});
            send_frame(d, msb, stop, 1'b0);
            idle(gap*D);
        end
        idle(3*D);
        chk("rand_le_count", ev_le.size() - base_le, exp_le.size());
        chk("rand_be_count", ev_be.size() - base_be, exp_be.size());
        for (int i = 0; i < exp_le.size(); i++) begin
            if (base_le + i < ev_le.size()) begin
                chk($sformatf("rand%0d_le_err", i), int'(ev_le[base_le+i].err), int'(exp_le[i].err));
                chk($sformatf("rand%0d_le_data", i), ev_le[base_le+i].data, exp_le[i].data);
            end
            if (base_be + i < ev_be.size())
                chk($sformatf("rand%0d_be_data", i), ev_be[base_be+i].data, exp_be[i].data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; direct downstream consumer of the serial line driven by uart_tx.
- Oversamples the asynchronous rx line with clk, aligns to the start-bit falling edge, and samples each bit at mid-period.
- Emits the assembled word with a one-cycle valid strobe, or flags a framing error.
- Frame format matches uart_tx exactly: 1 start bit (0), WIDTH data bits, 1 stop bit (1), no parity, DIVISOR clk cycles per bit.

Parameters:
- WIDTH, 8, data bits per frame.
- DIVISOR, 100, clk cycles per bit; must be even, >=4 (>=6 with UART_RX_GLITCH_FILTER_EN).
- LITTLE_ENDIAN, 1, 1 = first received bit is LSB; 0 = first received bit is MSB.

Ports:
- clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idles high.
- o_data  output  WIDTH  last correctly framed word; held until the next good frame.
- o_dv  output  1  one-cycle pulse; o_data updated in the same cycle.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- o_busy  output  1  high while in START, DATA or STOP.

Behaviour:
- Synchroniser: two flops on i_rx, both reset to 1, giving rx_s; a third flop holds rx_prev, also reset to 1.
- Reset values: state IDLE, bit counter 0, sub-bit counter 0, o_data 0, o_dv 0, o_frame_err 0, o_busy 0.
- Reset mid-frame: abort immediately; no o_dv or o_frame_err for the partial frame.
- Sub-bit counter cnt runs 0..DIVISOR-1 in every non-IDLE state. Sample point M = DIVISOR/2-1.
- IDLE:
  - Enter START when rx_prev==1 && rx_s==0 (falling edge); cnt<=0.
  - A line held low never retriggers; a new edge is required.
- START:
  - At cnt==M, if rx_s==1 this is a false start: return to IDLE with no output.
  - At cnt==DIVISOR-1, go to DATA; bit counter <= 0.
- DATA:
  - At cnt==M, shift the sample into the shift register. LITTLE_ENDIAN=1: shift right, insert at MSB. LITTLE_ENDIAN=0: shift left, insert at LSB.
  - At cnt==DIVISOR-1, increment the bit counter; after bit WIDTH-1, go to STOP.
- STOP:
  - At cnt==M: if rx_s==1, then o_data<=shift register and o_dv=1 next cycle. Otherwise o_frame_err=1 next cycle and o_data is unchanged.
  - Either way, return to IDLE at cnt==M, so the next start edge (back-to-back frames from uart_tx) is caught.
- o_dv and o_frame_err are mutually exclusive and last exactly one cycle.
- Latency: o_dv rises (WIDTH+1)*DIVISOR + DIVISOR/2 + 3 cycles (±1) after the i_rx falling edge of the start bit.
- Clock-rate tolerance: the receiver accepts transmitter rate error up to ±(DIVISOR/2-2)/((WIDTH+1.5)*DIVISOR).

Optional Feature:
- Macro: UART_RX_GLITCH_FILTER_EN.
- Defined: each bit decision (start, data, stop) is the majority of rx_s samples at cnt==M-1, M and M+1. The decision and its actions occur at cnt==M+1, and all latencies grow by 1.
- Undefined: single sample at cnt==M, as described above.
- Port list is unchanged either way.

Test Plan:
- Loopback with uart_tx (WIDTH=8, DIVISOR=16, LITTLE_ENDIAN=1), send 0xA5 -> one o_dv with o_data=0xA5, o_frame_err never set, o_busy high across the frame.
- Same loopback with LITTLE_ENDIAN=0 on both blocks, send 0x3C -> o_data=0x3C.
- Back-to-back 0x00, 0xFF, 0x81 with i_dv held on uart_tx -> three o_dv pulses in order with matching data, no frame errors.
- Drive i_rx low for DIVISOR/4 cycles, then high -> no o_dv, no o_frame_err; o_busy returns low within DIVISOR/2+3 cycles.
- Direct-drive a frame of 0x55 with stop bit 0, then hold i_rx low for 3 frames -> exactly one o_frame_err pulse, o_data keeps its prior value, no retrigger until i_rx returns high.
- Assert i_reset for 1 cycle mid-DATA, then send 0x42 cleanly -> no output from the aborted frame, then o_dv with 0x42. With UART_RX_GLITCH_FILTER_EN, a 1-cycle inverted glitch at cnt==M of every data bit of 0x42 still yields o_data=0x42.
